// File: rtl/seq_logger_pkg.sv
// seq_logger_pkg: shared defaults and record layout for the sequence event logger.
//   TS_W_DEF / ID_W_DEF / DEPTH_DEF : default timestamp width, ID width, FIFO depth
//   DROP_CNT_W                      : width of the optional saturating drop counter
//   evt_rec_t                       : packed {id, timestamp} record at default widths
package seq_logger_pkg;
   localparam int TS_W_DEF   = 16;
   localparam int ID_W_DEF   = 8;
   localparam int DEPTH_DEF  = 4;
   localparam int DROP_CNT_W = 16;

   typedef struct packed {
      logic [ID_W_DEF-1:0] id;
      logic [TS_W_DEF-1:0] timestamp;
   } evt_rec_t;
endpackage

// File: rtl/seq_event_fifo.sv
// seq_event_fifo: synchronous first-word fall-through FIFO with registered storage.
//   clk, reset_n (async, active-low), clear (sync flush)
//   push/wdata : write request; accepted when not full or when a pop happens together
//   pop        : read request; ignored while empty
//   rdata      : head entry, valid whenever empty=0
//   full/empty/level : occupancy status
module seq_event_fifo #(
   parameter int W     = 24,
   parameter int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             push,
   input  logic [W-1:0]     wdata,
   input  logic             pop,
   output logic [W-1:0]     rdata,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level
);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   assign empty   = (level == '0);
   assign full    = (level == LVL_W'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot the push needs, even when full.
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr];

   // Storage is zeroed on reset so the head reads 0 while empty after reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (do_push && !clear) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end
endmodule

// File: rtl/seq_event_logger.sv
// seq_event_logger: timestamps and numbers each sequence_found strobe and queues
// the records in a small FWFT FIFO drained over valid/ready.
//   clk, reset_n (async, active-low), clear (sync flush, highest priority)
//   sequence_found : one event per high cycle
//   evt_valid/evt_ready, evt_timestamp, evt_id : head-of-queue handshake and data
//   fifo_level     : occupied entries
//   overflow       : sticky, an event was dropped because the queue was full
//   drop_count     : saturating dropped-event count, present only with
//                    SEQ_EVENT_DROP_CNT_EN defined
module seq_event_logger
   import seq_logger_pkg::*;
#(
   parameter int TS_W  = TS_W_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int ID_W  = ID_W_DEF
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       clear,
   input  logic                       sequence_found,
   output logic                       evt_valid,
   input  logic                       evt_ready,
   output logic [TS_W-1:0]            evt_timestamp,
   output logic [ID_W-1:0]            evt_id,
   output logic [$clog2(DEPTH):0]     fifo_level,
   output logic                       overflow
`ifdef SEQ_EVENT_DROP_CNT_EN
   ,output logic [DROP_CNT_W-1:0]     drop_count
`endif
);
   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [TS_W-1:0] timestamp;
   } rec_t;

   rec_t            wr_rec, rd_rec;
   logic [TS_W-1:0] ts_q;
   logic [ID_W-1:0] id_q;
   logic            fifo_full, fifo_empty;
   logic            push, pop, drop;

   // clear voids any coincident event and pop.
   assign push = sequence_found & ~clear;
   assign pop  = ~fifo_empty & evt_ready & ~clear;
   assign drop = push & fifo_full & ~pop;

   assign wr_rec.id        = id_q;
   assign wr_rec.timestamp = ts_q;

   seq_event_fifo #(.W(ID_W + TS_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (clear),
      .push    (push),
      .wdata   (wr_rec),
      .pop     (pop),
      .rdata   (rd_rec),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   assign evt_valid     = ~fifo_empty;
   assign evt_timestamp = rd_rec.timestamp;
   assign evt_id        = rd_rec.id;

   // The ID advances on dropped events too, so consumers see gaps.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ts_q     <= '0;
         id_q     <= '0;
         overflow <= 1'b0;
      end else if (clear) begin
         ts_q     <= '0;
         id_q     <= '0;
         overflow <= 1'b0;
      end else begin
         ts_q <= ts_q + 1'b1;
         if (push) id_q <= id_q + 1'b1;
         if (drop) overflow <= 1'b1;
      end
   end

`ifdef SEQ_EVENT_DROP_CNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                    drop_count <= '0;
      else if (clear)                  drop_count <= '0;
      else if (drop && drop_count != '1) drop_count <= drop_count + 1'b1;
   end
`endif
endmodule
